// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit holding the HI/LO registers
// Ports: clk, reset (sync, active-high); start_i/op_i/a_i/b_i issue an operation
// (000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op);
// busy_o stalls issue and HI/LO reads, done_o/divzero_o pulse on completion, hi_o/lo_o are HI/LO.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they run as MULTU/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mb_q, mb_d, rem_q, rem_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, aneg_q, aneg_d, div_q, div_d, dz_q, dz_d;
    logic               busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

    logic               sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, sub, quo, rmd;
    logic [WIDTH:0]     mul_sum, shifted;
    logic [2*WIDTH-1:0] prod_fix;
    logic               ge;

`ifdef MULDIV_SIGNED_EN
    assign sgn      = op_i[0];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quo      = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rmd      = aneg_q ? -rem_q : rem_q;
`else
    assign sgn      = 1'b0;
    assign a_mag    = a_i;
    assign b_mag    = b_i;
    assign prod_fix = prod_q;
    assign quo      = prod_q[WIDTH-1:0];
    assign rmd      = rem_q;
`endif
    assign a_neg  = sgn & a_i[WIDTH-1];
    assign b_neg  = sgn & b_i[WIDTH-1];
    assign b_zero = b_i == '0;

    // Multiply: low half starts as the multiplier and is consumed LSB-first while
    // the partial product grows into the high half.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? mb_q : '0};
    // Divide: low half starts as the dividend, shifted MSB-first into the partial
    // remainder; quotient bits are shifted in at the bottom. The difference is only
    // kept when it is non-negative, so it always fits WIDTH bits.
    assign shifted = {rem_q, prod_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, mb_q};
    assign sub     = shifted[WIDTH-1:0] - mb_q;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mb_d      = mb_q;
        rem_d     = rem_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        aneg_d    = aneg_q;
        div_d     = div_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                if (op_i[2]) begin
                    hi_d = op_i[1:0] == 2'b00 ? a_i : hi_q;
                    lo_d = op_i[1:0] == 2'b01 ? a_i : lo_q;
                end else begin
                    busy_d  = 1'b1;
                    div_d   = op_i[1];
                    dz_d    = op_i[1] & b_zero;
                    neg_d   = a_neg ^ b_neg;
                    aneg_d  = a_neg;
                    mb_d    = b_mag;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    // A zero divisor keeps the raw dividend so FIX can return it in HI.
                    prod_d  = {{WIDTH{1'b0}}, (op_i[1] & b_zero) ? a_i : a_mag};
                    state_d = (op_i[1] & b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? S_FIX : S_RUN;
                if (div_q) begin
                    rem_d              = ge ? sub : shifted[WIDTH-1:0];
                    prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], ge};
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                divzero_d = dz_q;
                if (dz_q) begin
                    hi_d = prod_q[WIDTH-1:0];
                    lo_d = '1;
                end else if (div_q) begin
                    hi_d = rmd;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            aneg_q    <= 1'b0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mb_q      <= mb_d;
            rem_q     <= rem_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            aneg_q    <= aneg_d;
            div_q     <= div_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign divzero_o = divzero_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
endmodule
